// File: rtl/ysyx_24100005_ifu_if.sv
// Fetch-unit bus bundle: memory request/response channel plus the datapath instruction/next-PC channel.
interface ysyx_24100005_ifu_if;
  localparam int unsigned XLEN = 32;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic            mem_rsp_ready;
  logic [XLEN-1:0] mem_rsp_data;
  logic            mem_rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;
  logic            npc_valid;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] pc;

  // IFU side
  modport master (
    output mem_req_valid, mem_req_addr, mem_rsp_ready,
    output inst_valid, inst, inst_pc, inst_fault, pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  inst_ready, npc_valid, npc
  );

  // Memory + datapath side
  modport slave (
    input  mem_req_valid, mem_req_addr, mem_rsp_ready,
    input  inst_valid, inst, inst_pc, inst_fault, pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output inst_ready, npc_valid, npc
  );
endinterface

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time and hands the word
// to the datapath, then waits for the resolved next PC before fetching again.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ERR_INST = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_24100005_ifu_if.master    bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2,
    S_EXEC    = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (bus.mem_req_ready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
            inst_q    <= bus.mem_rsp_err ? ERR_INST : bus.mem_rsp_data;
            fault_q   <= bus.mem_rsp_err;
            inst_pc_q <= pc_q;
            state_q   <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          if (bus.inst_ready) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (bus.npc_valid) begin
            pc_q <= bus.npc;
            // Misaligned target faults locally without touching memory
            if (bus.npc[1:0] != 2'b00) begin
              inst_q    <= ERR_INST;
              fault_q   <= 1'b1;
              inst_pc_q <= bus.npc;
              state_q   <= S_DELIVER;
            end else begin
              state_q   <= S_REQ;
            end
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  // Handshake strobes decode from state; gated so nothing is offered while reset is held
  assign bus.mem_req_valid = rst && (state_q == S_REQ);
  assign bus.mem_rsp_ready = rst && (state_q == S_WAIT);
  assign bus.inst_valid    = rst && (state_q == S_DELIVER);

  assign bus.mem_req_addr  = pc_q;
  assign bus.pc            = pc_q;
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.inst_fault    = fault_q;
endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed bench for the fetch unit with hand-computed expectations.
module tb_ysyx_24100005_ifu;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n_hs;

  ysyx_24100005_ifu_if bus ();

  ysyx_24100005_ifu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_hs    = 0;
    rst     = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_err   = 1'b0;
    bus.inst_ready    = 1'b0;
    bus.npc_valid     = 1'b0;
    bus.npc           = '0;

    // Reset values
    step();
    step();
    check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_rsp_ready", 32'(bus.mem_rsp_ready), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_pc", bus.pc, 32'h8000_0000);
    check("rst_addr", bus.mem_req_addr, 32'h8000_0000);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_fault", 32'(bus.inst_fault), 32'd0);

    // First fetch, zero-wait memory
    rst = 1'b1;
    #1;
    check("req0_valid", 32'(bus.mem_req_valid), 32'd1);
    check("req0_addr", bus.mem_req_addr, 32'h8000_0000);
    bus.mem_req_ready = 1'b1;
    step();
    check("wait0_rsp_ready", 32'(bus.mem_rsp_ready), 32'd1);
    check("wait0_req_valid", 32'(bus.mem_req_valid), 32'd0);
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0010_0093;
    step();
    bus.mem_rsp_valid = 1'b0;
    check("dlv0_valid", 32'(bus.inst_valid), 32'd1);
    check("dlv0_inst", bus.inst, 32'h0010_0093);
    check("dlv0_inst_pc", bus.inst_pc, 32'h8000_0000);
    check("dlv0_fault", 32'(bus.inst_fault), 32'd0);
    check("dlv0_rsp_ready", 32'(bus.mem_rsp_ready), 32'd0);

    // Datapath stalls; a stray npc_valid must be ignored
    for (int i = 0; i < 5; i++) begin
      bus.npc_valid = (i == 2);
      bus.npc       = 32'h0000_1234;
      check("stall_valid", 32'(bus.inst_valid), 32'd1);
      check("stall_inst", bus.inst, 32'h0010_0093);
      check("stall_inst_pc", bus.inst_pc, 32'h8000_0000);
      step();
    end
    bus.npc_valid = 1'b0;
    check("stall_pc", bus.pc, 32'h8000_0000);

    // Accept, then supply an aligned next PC
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check("exec_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("exec_req_valid", 32'(bus.mem_req_valid), 32'd0);
    bus.npc_valid = 1'b1;
    bus.npc       = 32'h8000_0010;
    step();
    bus.npc_valid = 1'b0;
    check("npc_pc", bus.pc, 32'h8000_0010);
    check("npc_req_valid", 32'(bus.mem_req_valid), 32'd1);

    // Memory back-pressure: request held for 3 cycles then accepted once
    for (int i = 0; i < 4; i++) begin
      bus.mem_req_ready = (i == 3);
      check("bp_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check("bp_addr", bus.mem_req_addr, 32'h8000_0010);
      if (bus.mem_req_valid && bus.mem_req_ready) n_hs++;
      step();
    end
    bus.mem_req_ready = 1'b0;
    check("bp_after_valid", 32'(bus.mem_req_valid), 32'd0);
    check("bp_handshakes", 32'(n_hs), 32'd1);

    // Faulting response
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_err   = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD_BEEF;
    step();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err   = 1'b0;
    check("err_valid", 32'(bus.inst_valid), 32'd1);
    check("err_inst", bus.inst, 32'h0000_0000);
    check("err_fault", 32'(bus.inst_fault), 32'd1);
    check("err_inst_pc", bus.inst_pc, 32'h8000_0010);

    // Misaligned next PC: direct to DELIVER, no memory request
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b1;
    bus.npc        = 32'h8000_0102;
    step();
    bus.npc_valid  = 1'b0;
    check("mis_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("mis_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("mis_fault", 32'(bus.inst_fault), 32'd1);
    check("mis_inst", bus.inst, 32'h0000_0000);
    check("mis_inst_pc", bus.inst_pc, 32'h8000_0102);
    check("mis_pc", bus.pc, 32'h8000_0102);

    // Back to an aligned fetch, then reset while a response is arriving
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b1;
    bus.npc        = 32'h8000_0004;
    step();
    bus.npc_valid  = 1'b0;
    check("re_addr", bus.mem_req_addr, 32'h8000_0004);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    check("re_wait_rsp_ready", 32'(bus.mem_rsp_ready), 32'd1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h1234_5678;
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_rsp_ready", 32'(bus.mem_rsp_ready), 32'd0);
    check("mid_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("mid_rst_pc", bus.pc, 32'h8000_0000);
    step();
    bus.mem_rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("post_rst_req_valid", 32'(bus.mem_req_valid), 32'd1);
    check("post_rst_addr", bus.mem_req_addr, 32'h8000_0000);
    check("post_rst_inst", bus.inst, 32'h0);
    check("post_rst_fault", 32'(bus.inst_fault), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_24100005_ifu.md
Name: ysyx_24100005_ifu

Overview:
Instruction fetch unit that sits directly upstream of the core datapath and supplies its `inst` input. It holds the architectural PC and issues one fetch at a time on a valid/ready memory request/response interface. It presents the fetched word plus its PC to the datapath on a valid/ready handshake, then waits for the datapath's next-PC before starting the next fetch. This converts the single-cycle core into a multi-cycle core that tolerates arbitrary memory latency.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset and first fetch address
ERR_INST, 32'h0000_0000, instruction word delivered when a fetch faults

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, asynchronous, active-low
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  fetch address, always current pc
mem_rsp_valid  in  1  fetch response valid
mem_rsp_ready  out  1  IFU accepts response
mem_rsp_data  in  32  fetched instruction word
mem_rsp_err  in  1  access fault on this response
inst_valid  out  1  inst/inst_pc/inst_fault valid to datapath
inst_ready  in  1  datapath accepts instruction
inst  out  32  instruction word
inst_pc  out  32  PC of inst
inst_fault  out  1  1 = fetch error or misaligned PC; inst = ERR_INST
npc_valid  in  1  datapath has resolved next PC
npc  in  32  next PC (SPC or branch/jump target)
pc  out  32  architectural PC register

Behaviour:
- Reset (rst=0, async): state=REQ, pc=RESET_PC, inst=0, inst_pc=0, inst_fault=0. mem_req_valid, mem_rsp_ready and inst_valid are all 0 while rst=0. mem_req_addr=pc.
- FSM states: REQ, WAIT, DELIVER, EXEC. The outputs decode from state as follows:
  - mem_req_valid = (state==REQ)
  - mem_rsp_ready = (state==WAIT)
  - inst_valid = (state==DELIVER)
- REQ: mem_req_valid=1 with addr=pc, held stable until mem_req_ready. On mem_req_valid&&mem_req_ready, go to WAIT.
- WAIT: on mem_rsp_valid, register the response and go to DELIVER:
  - inst<=mem_rsp_data, or ERR_INST if mem_rsp_err
  - inst_fault<=mem_rsp_err
  - inst_pc<=pc
- DELIVER: inst, inst_pc and inst_fault are held stable while inst_valid=1. On inst_ready, go to EXEC.
- EXEC: wait for npc_valid. On npc_valid, pc<=npc, then:
  - if npc[1:0]!=0: no memory request; go directly to DELIVER with inst=ERR_INST, inst_fault=1, inst_pc=npc.
  - else go to REQ.
- npc_valid outside EXEC is ignored. mem_rsp_valid outside WAIT is ignored and not acknowledged. At most one fetch is outstanding.
- Latency with zero-wait memory (req_ready=1 in REQ; rsp_valid on first WAIT cycle) and inst_ready=1:
  - REQ→inst_valid: 2 cycles.
  - REQ→next REQ: 4 cycles if npc_valid arrives on the first EXEC cycle.
- Reset mid-operation, in any state: abort immediately to reset values. A response in flight from before reset is not tracked; the memory side is also reset by the same rst.
- pc changes only on reset or the EXEC→(REQ|DELIVER) transition. pc is never incremented internally; PC+4 is the datapath's job.

Test Plan:
- Reset release, mem_req_ready=1, rsp next cycle data=32'h0010_0093 → mem_req_addr=32'h8000_0000; inst_valid 2 cycles after REQ with inst=32'h0010_0093, inst_pc=32'h8000_0000, inst_fault=0.
- mem_req_ready low 3 cycles, then high → mem_req_valid stays 1 and addr stable for all 4 cycles; exactly one request handshake.
- inst_ready held low 5 cycles in DELIVER → inst_valid=1 and inst/inst_pc unchanged throughout; a stray npc_valid pulse in this window leaves pc unchanged.
- Response with mem_rsp_err=1, data=32'hDEAD_BEEF → inst=32'h0000_0000, inst_fault=1, inst_pc=faulting PC.
- In EXEC, npc=32'h8000_0102 → no mem_req_valid; next cycle inst_valid=1, inst_fault=1, inst_pc=32'h8000_0102. Separately, npc=32'h8000_0010 → pc=32'h8000_0010 and the next request addr is 32'h8000_0010.
- Assert rst while in WAIT with mem_rsp_valid=1 → same cycle: mem_rsp_ready=0, inst_valid=0. After release: pc=32'h8000_0000 and a fresh request at 32'h8000_0000.
